// File: rtl/vga_pkg.sv
// Shared types, the 4x4 Bayer threshold table and colour helpers for the VGA output stage.
package vga_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    // Element index is {row[1:0], col[1:0]}; the leftmost entry is index 15.
    localparam logic [15:0][3:0] BAYER4 = {
        4'd5,  4'd13, 4'd7,  4'd15,
        4'd9,  4'd1,  4'd11, 4'd3,
        4'd6,  4'd14, 4'd4,  4'd12,
        4'd10, 4'd2,  4'd8,  4'd0
    };

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        IDLE    = 2'd1,
        ACTIVE  = 2'd2
    } geom_state_t;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Scale a 4-bit Bayer threshold to span the bits dropped by truncation.
    function automatic logic [7:0] bayer_thr(input logic [3:0] idx, input int unsigned drop);
        logic [7:0] t;
        t = {4'd0, BAYER4[idx]};
        if (drop >= 32'd4) begin
            return t << (drop - 32'd4);
        end else begin
            return t >> (32'd4 - drop);
        end
    endfunction

endpackage

// File: rtl/delay_line.sv
// N-stage register delay with asynchronous active-low clear; N = 0 degenerates to a wire.
module delay_line #(
    parameter int W = 1,
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (N == 0) begin : g_wire
            logic unused_s;
            assign unused_s = clk ^ rst_n;
            assign dout     = din;
        end else begin : g_taps
            logic [W-1:0] taps_r [N];

            // Shift chain, tap 0 takes the input.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < N; i++) taps_r[i] <= {W{1'b0}};
                end else begin
                    taps_r[0] <= din;
                    for (int i = 1; i < N; i++) taps_r[i] <= taps_r[i-1];
                end
            end

            assign dout = taps_r[N-1];
        end
    endgenerate

endmodule

// File: rtl/vga_out_stage.sv
// Final VGA pixel stage: aligns timing to draw data, blanks/reduces colour, applies sync polarity,
// and monitors line/frame geometry. Define DITHER_EN to add 4x4 ordered dither before truncation.
module vga_out_stage
    import vga_pkg::*;
#(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int DATA_LAT = 1,
    parameter int OUT_BITS = 4,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      h_sync,
    input  logic                      v_sync,
    input  logic                      de,
    input  logic [$clog2(WIDTH)-1:0]  x,
    input  logic [$clog2(HEIGHT)-1:0] y,
    input  logic [23:0]               data,
    output logic                      vga_hs,
    output logic                      vga_vs,
    output logic                      vga_de,
    output logic [OUT_BITS-1:0]       vga_r,
    output logic [OUT_BITS-1:0]       vga_g,
    output logic [OUT_BITS-1:0]       vga_b,
    output logic [1:0]                geom_err,
    output logic [15:0]               frame_cnt
);

    localparam int XW   = $clog2(WIDTH);
    localparam int YW   = $clog2(HEIGHT);
    localparam int PW   = $clog2(WIDTH + 1);
    localparam int LW   = $clog2(HEIGHT + 1);
    localparam int DROP = 8 - OUT_BITS;

    logic   hs_d_s, vs_d_s, de_d_s;
    rgb24_t pix_s, adj_s;
    logic   unused_s;

    assign pix_s = data;

`ifdef DITHER_EN
    logic [XW-1:0] x_d_s;
    logic [YW-1:0] y_d_s;
    logic [7:0]    thr_s;

    delay_line #(.W(3 + XW + YW), .N(DATA_LAT)) u_timing_dly (
        .clk   (clk),
        .rst_n (reset),
        .din   ({h_sync, v_sync, de, x, y}),
        .dout  ({hs_d_s, vs_d_s, de_d_s, x_d_s, y_d_s})
    );

    assign thr_s = bayer_thr({y_d_s[1:0], x_d_s[1:0]}, DROP);

    // Dither each channel with the tile threshold, saturating before truncation.
    always_comb begin
        adj_s   = pix_s;
        adj_s.r = sat_add8(pix_s.r, thr_s);
        adj_s.g = sat_add8(pix_s.g, thr_s);
        adj_s.b = sat_add8(pix_s.b, thr_s);
    end

    assign unused_s = ^{adj_s, x_d_s, y_d_s};
`else
    delay_line #(.W(3), .N(DATA_LAT)) u_timing_dly (
        .clk   (clk),
        .rst_n (reset),
        .din   ({h_sync, v_sync, de}),
        .dout  ({hs_d_s, vs_d_s, de_d_s})
    );

    assign adj_s    = pix_s;
    assign unused_s = ^{adj_s, x, y};
`endif

    // Output register: polarity, blanking and channel reduction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vga_hs <= ~HS_POL;
            vga_vs <= ~VS_POL;
            vga_de <= 1'b0;
            vga_r  <= {OUT_BITS{1'b0}};
            vga_g  <= {OUT_BITS{1'b0}};
            vga_b  <= {OUT_BITS{1'b0}};
        end else begin
            vga_hs <= HS_POL ? hs_d_s : ~hs_d_s;
            vga_vs <= VS_POL ? vs_d_s : ~vs_d_s;
            vga_de <= de_d_s;
            vga_r  <= de_d_s ? adj_s.r[7 -: OUT_BITS] : {OUT_BITS{1'b0}};
            vga_g  <= de_d_s ? adj_s.g[7 -: OUT_BITS] : {OUT_BITS{1'b0}};
            vga_b  <= de_d_s ? adj_s.b[7 -: OUT_BITS] : {OUT_BITS{1'b0}};
        end
    end

    geom_state_t state_r;
    logic        vs_p_r, de_p_r;
    logic [PW-1:0] pix_cnt_r;
    logic [LW-1:0] line_cnt_r;
    logic [1:0]    geom_err_r;
    logic [15:0]   frame_cnt_r;
    logic          vs_rise_s, de_rise_s, pix_bad_s;
    logic [PW-1:0] pix_inc_s;
    logic [LW-1:0] line_inc_s;

    assign vs_rise_s  = vs_d_s & ~vs_p_r;
    assign de_rise_s  = de_d_s & ~de_p_r;
    assign pix_bad_s  = (pix_cnt_r != PW'(WIDTH));
    assign pix_inc_s  = (pix_cnt_r == {PW{1'b1}}) ? pix_cnt_r : pix_cnt_r + {{(PW-1){1'b0}}, 1'b1};
    assign line_inc_s = (line_cnt_r == {LW{1'b1}}) ? line_cnt_r : line_cnt_r + {{(LW-1){1'b0}}, 1'b1};

    // Geometry monitor and frame counter; a line cut by v_sync is closed before the frame check.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= WAIT_VS;
            vs_p_r      <= 1'b0;
            de_p_r      <= 1'b0;
            pix_cnt_r   <= {PW{1'b0}};
            line_cnt_r  <= {LW{1'b0}};
            geom_err_r  <= 2'b00;
            frame_cnt_r <= 16'd0;
        end else begin
            vs_p_r <= vs_d_s;
            de_p_r <= de_d_s;
            if (vs_rise_s) frame_cnt_r <= frame_cnt_r + 16'd1;
            case (state_r)
                WAIT_VS: begin
                    if (vs_rise_s) begin
                        state_r    <= IDLE;
                        line_cnt_r <= {LW{1'b0}};
                    end
                end
                IDLE: begin
                    if (vs_rise_s) begin
                        if (line_cnt_r != LW'(HEIGHT)) geom_err_r[1] <= 1'b1;
                        line_cnt_r <= {LW{1'b0}};
                    end
                    if (de_rise_s) begin
                        state_r   <= ACTIVE;
                        pix_cnt_r <= {{(PW-1){1'b0}}, 1'b1};
                    end
                end
                ACTIVE: begin
                    if (vs_rise_s || !de_d_s) begin
                        if (pix_bad_s) geom_err_r[0] <= 1'b1;
                        if (vs_rise_s) begin
                            if (line_inc_s != LW'(HEIGHT)) geom_err_r[1] <= 1'b1;
                            line_cnt_r <= {LW{1'b0}};
                        end else begin
                            line_cnt_r <= line_inc_s;
                        end
                        state_r <= IDLE;
                    end else begin
                        pix_cnt_r <= pix_inc_s;
                    end
                end
                default: state_r <= WAIT_VS;
            endcase
        end
    end

    assign geom_err  = geom_err_r;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_vga_out_stage.sv
// Bench for vga_out_stage: per-cycle scoreboard on the pixel outputs plus frame-level geometry checks.
module tb_vga_out_stage;

    localparam int WIDTH    = 8;
    localparam int HEIGHT   = 4;
    localparam int DATA_LAT = 2;
    localparam int OUT_BITS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        h_sync, v_sync, de;
    logic [2:0]  x;
    logic [1:0]  y;
    logic [23:0] data;
    logic        vga_hs, vga_vs, vga_de;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic [1:0]  geom_err;
    logic [15:0] frame_cnt;

    vga_out_stage #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .DATA_LAT(DATA_LAT), .OUT_BITS(OUT_BITS),
        .HS_POL(1'b0), .VS_POL(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync), .de(de),
        .x(x), .y(y), .data(data), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .geom_err(geom_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [23:0] data; logic [11:0] exp; } vec_t;
    typedef struct { logic [14:0] word; bit tile; } exp_t;

    vec_t        vecs [8];
    exp_t        sb_q [$];
    logic [23:0] col_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cur_y = 0;
    int          tile_ones = 0;
    bit          tally_en = 1'b0;

`ifdef DITHER_EN
    int bayer_tb [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
`endif

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected 4-bit channels for a pixel at (xi, yi).
    function automatic logic [11:0] exp_px(input logic [23:0] c, input int xi, input int yi);
        logic [11:0] r;
        logic [8:0]  ch;
        int          t;
        t = 0;
`ifdef DITHER_EN
        t = bayer_tb[(yi % 4) * 4 + (xi % 4)];
`endif
        for (int k = 0; k < 3; k++) begin
            ch = {1'b0, c[k*8 +: 8]} + 9'(t);
            if (ch > 9'd255) ch = 9'd255;
            r[k*4 +: 4] = ch[7:4];
        end
        return r;
    endfunction

    task automatic step(input logic hs_i, input logic vs_i, input logic de_i, input int xi,
                        input logic [23:0] col, input logic [11:0] exp_rgb);
        exp_t e, g;
        h_sync = hs_i;
        v_sync = vs_i;
        de     = de_i;
        x      = xi[2:0];
        y      = cur_y[1:0];
        col_q.push_back(col);
        data   = col_q.pop_front();
        e.word = {~hs_i, vs_i, de_i, de_i ? exp_rgb : 12'h000};
        e.tile = tally_en && de_i && (xi < 4);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 3) begin
            g = sb_q.pop_front();
            chk("pix", 32'({vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b}), 32'(g.word));
            if (g.tile && vga_r == 4'h1) tile_ones++;
        end
    endtask

    task automatic blank(input logic hs_i, input logic vs_i);
        step(hs_i, vs_i, 1'b0, 0, 24'($urandom), 12'h000);
    endtask

    task automatic send_line(input int n, input bit fixed, input logic [23:0] fcol);
        logic [23:0] c;
        logic [11:0] e;
        for (int i = 0; i < n; i++) begin
            c = fixed ? fcol : vecs[i % 8].data;
            e = exp_px(c, i, cur_y);
`ifndef DITHER_EN
            if (!fixed) e = vecs[i % 8].exp;
`endif
            step(1'b0, 1'b0, 1'b1, i, c, e);
        end
        blank(1'b1, 1'b0);
        blank(1'b1, 1'b0);
        blank(1'b0, 1'b0);
        cur_y++;
    endtask

    task automatic send_lines(input int n);
        for (int l = 0; l < n; l++) send_line(WIDTH, 1'b0, 24'h0);
    endtask

    task automatic send_vs();
        blank(1'b0, 1'b1);
        blank(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) blank(1'b0, 1'b0);
        cur_y = 0;
    endtask

    task automatic restart_queues();
        sb_q.delete();
        col_q.delete();
        col_q.push_back(24'h0);
        col_q.push_back(24'h0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hs"},   32'(vga_hs), 32'd1);
        chk({tag, "_vs"},   32'(vga_vs), 32'd0);
        chk({tag, "_de"},   32'(vga_de), 32'd0);
        chk({tag, "_rgb"},  32'({vga_r, vga_g, vga_b}), 32'h0);
        chk({tag, "_geom"}, 32'(geom_err), 32'd0);
        chk({tag, "_fcnt"}, 32'(frame_cnt), 32'd0);
    endtask

    initial begin
        vecs[0] = '{24'hAB_CD_EF, 12'hACE};
        vecs[1] = '{24'h00_00_00, 12'h000};
        vecs[2] = '{24'hFF_FF_FF, 12'hFFF};
        vecs[3] = '{24'h12_34_56, 12'h135};
        vecs[4] = '{24'h0F_F0_80, 12'h0F8};
        vecs[5] = '{24'h7F_80_01, 12'h780};
        vecs[6] = '{24'h80_7F_FE, 12'h87F};
        vecs[7] = '{24'h10_2F_3C, 12'h123};

        reset  = 1'b0;
        h_sync = 1'b0; v_sync = 1'b0; de = 1'b0; x = 3'd0; y = 2'd0; data = 24'h0;
        #12;
        chk_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b1;
        restart_queues();

        // Clean frames: frame counter steps 1, 2, 3 with no geometry error.
        send_vs();
        chk("fcnt1", 32'(frame_cnt), 32'd1);
        send_lines(HEIGHT);
        send_vs();
        chk("geom_clean1", 32'(geom_err), 32'd0);
        chk("fcnt2", 32'(frame_cnt), 32'd2);
        send_lines(HEIGHT);
        send_vs();
        chk("geom_clean2", 32'(geom_err), 32'd0);
        chk("fcnt3", 32'(frame_cnt), 32'd3);

        // Short line flags bit 0, which stays set; a 3-line frame then flags bit 1.
        send_line(WIDTH, 1'b0, 24'h0);
        send_line(WIDTH - 1, 1'b0, 24'h0);
        send_lines(2);
        send_vs();
        chk("geom_short", 32'(geom_err), 32'd1);
        chk("fcnt4", 32'(frame_cnt), 32'd4);
        send_lines(HEIGHT);
        send_vs();
        chk("geom_sticky", 32'(geom_err), 32'd1);
        send_lines(HEIGHT - 1);
        send_vs();
        chk("geom_lines", 32'(geom_err), 32'd3);
        chk("fcnt6", 32'(frame_cnt), 32'd6);

        // Reset in the middle of a line: immediate reset values, partial frame not flagged.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, i, vecs[i].data, exp_px(vecs[i].data, i, cur_y));
        reset = 1'b0;
        h_sync = 1'b0; v_sync = 1'b0; de = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b1;
        restart_queues();
        cur_y = 1;
        for (int i = 0; i < 3; i++) blank(1'b0, 1'b0);
        chk("post_rst_fcnt", 32'(frame_cnt), 32'd0);
        send_lines(HEIGHT - 1);
        send_vs();
        chk("partial_geom", 32'(geom_err), 32'd0);
        chk("post_rst_fcnt1", 32'(frame_cnt), 32'd1);
        send_lines(HEIGHT);
        send_vs();
        chk("post_rst_geom", 32'(geom_err), 32'd0);
        chk("post_rst_fcnt2", 32'(frame_cnt), 32'd2);

`ifdef DITHER_EN
        // One 4x4 tile of 0x08: half the thresholds carry into the kept nibble.
        tally_en = 1'b1;
        for (int l = 0; l < 4; l++) send_line(WIDTH, 1'b1, 24'h08_08_08);
        tally_en = 1'b0;
        chk("dither_ones", 32'(tile_ones), 32'd8);
        for (int l = 0; l < 4; l++) send_line(WIDTH, 1'b1, 24'hFF_FF_FF);
        send_vs();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
